mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Memory-stage request controller that consumes the X/M pipeline register outputs: memory read/write controls, ALU address, store data and halt.
- Drives a variable-latency data memory (done/hit handshake) and returns the load data.
- Generates the stall that holds the F/D, D/X and X/M pipeline registers while an access is outstanding.
- Reports misaligned-access and timeout errors toward the error chain.

Parameters:
- TIMEOUT, 64, maximum cycles a request may stay outstanding (BUSY) before a timeout error.
- CNT_W, 8, width of the outstanding-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memRead_IN  in  1  load request from X/M.
- memWrite_IN  in  1  store request from X/M.
- halt_IN  in  1  halt instruction in M stage.
- err_IN  in  1  upstream error carried through X/M.
- addr_IN  in  16  ALU output used as byte address.
- wdata_IN  in  16  store data.
- mem_done  in  1  memory completes the current access this cycle.
- mem_rdata  in  16  memory read data; valid when mem_done=1.
- mem_en  out  1  request valid to memory.
- mem_wr  out  1  1 = write, 0 = read; meaningful only when mem_en=1.
- mem_addr  out  16  request address.
- mem_wdata  out  16  request write data.
- stall  out  1  hold upstream pipeline registers.
- rdata_OUT  out  16  load result to M/W.
- err_OUT  out  1  error to M/W.
- halt_OUT  out  1  halt to M/W.

Behaviour:
- States: IDLE, BUSY, HALTED, ERR. Reset: asynchronous, state=IDLE, counter=0, hold registers=0; no outputs are registered, so all outputs evaluate to 0 from IDLE with inputs low.
- req = (memRead_IN | memWrite_IN) & ~err_IN. If both read and write are set, treat the access as a write.
- misalign = req & addr_IN[0].

IDLE:
- If misalign: no request issued, err_OUT=1, stall=0; next state ERR.
- If req and not misaligned: mem_en=1, with mem_wr/mem_addr/mem_wdata taken combinationally from the inputs.
  - mem_done=1 the same cycle (hit): stall=0; rdata_OUT=mem_rdata for a read, 0 for a write; remain IDLE.
  - mem_done=0: stall=1; latch wr/addr/wdata into hold registers; counter=1; next state BUSY.
- If halt_IN & ~req: halt_OUT=1; next state HALTED.
- Otherwise: all outputs 0; err_OUT=err_IN.

BUSY:
- mem_en=1; request fields are driven from the hold registers, so the request is stable regardless of inputs.
- stall=1 while mem_done=0; counter increments each cycle.
- mem_done=1: stall=0 that cycle; rdata_OUT=mem_rdata for a read, 0 for a write; counter cleared; next state IDLE. Zero-bubble return.
- counter==TIMEOUT with mem_done=0: mem_en=0, stall=0, err_OUT=1; next state ERR.
- X/M inputs are ignored in BUSY; they are frozen by stall.

HALTED:
- halt_OUT=1 and mem_en=0 permanently; stall=0; exit only by reset.

ERR:
- err_OUT=1 sticky; mem_en=0; stall=0; exit only by reset.

Common rules:
- err_OUT = err_IN | misalign | timeout | (state==ERR).
- Reset asserted mid-BUSY: the request is dropped immediately (mem_en=0, stall=0); the memory model is also reset by the same rst.
- Maximum stall length is TIMEOUT cycles.
- Back-to-back accesses: a new request may be issued in the IDLE cycle that follows completion.

Test Plan:
- Hit load: memRead=1, addr=0x0010, mem_done=1 same cycle with rdata=0xBEEF -> mem_en=1, stall=0, rdata_OUT=0xBEEF, state stays IDLE.
- Miss store: memWrite=1, addr=0x0020, wdata=0x1234, mem_done at cycle 4 -> stall=1 for cycles 0–3 and 0 in cycle 4; mem_addr/mem_wdata hold 0x0020/0x1234 in cycles 0–4 even if inputs change to 0xFFFF; mem_wr=1 throughout.
- Misaligned load: addr=0x0031 -> mem_en=0 and err_OUT=1 in that cycle; err_OUT stays 1 for all later cycles; stall=0.
- Timeout: load with mem_done held 0 -> stall=1 until counter==64, then err_OUT=1 and mem_en=0; ERR state persists.
- Halt: halt_IN=1, no request -> halt_OUT=1 next and every later cycle; a subsequent memRead produces no mem_en.
- Reset mid-BUSY: rst=0 at cycle 2 of a miss -> mem_en, stall and err_OUT drop asynchronously; after release, a new hit read completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : M-stage request controller for a variable-latency data memory;
//            generates the upstream stall and misalign/timeout errors.
// Revision : 1.0
// ============================================================================
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead_IN,
  input  logic        memWrite_IN,
  input  logic        halt_IN,
  input  logic        err_IN,
  input  logic [15:0] addr_IN,
  input  logic [15:0] wdata_IN,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        stall,
  output logic [15:0] rdata_OUT,
  output logic        err_OUT,
  output logic        halt_OUT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic             r_holdWr;
  logic [15:0]      r_holdAddr;
  logic [15:0]      r_holdWdata;
  logic [CNT_W-1:0] r_cnt;

  logic w_req;
  logic w_misalign;
  logic w_timeout;

  assign w_req      = (memRead_IN | memWrite_IN) & ~err_IN;
  // X/M inputs are frozen while BUSY, so misalignment only matters in IDLE
  assign w_misalign = (r_state == IDLE) & w_req & addr_IN[0];
  assign w_timeout  = (r_state == BUSY) & ~mem_done & (r_cnt == C_TIMEOUT);

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    stall     = 1'b0;
    rdata_OUT = 16'h0000;
    halt_OUT  = 1'b0;
    err_OUT   = err_IN | w_misalign | w_timeout | (r_state == ERR);

    case (r_state)
      IDLE: begin
        if (w_req && !w_misalign) begin
          mem_en    = 1'b1;
          mem_wr    = memWrite_IN;
          mem_addr  = addr_IN;
          mem_wdata = wdata_IN;
          if (mem_done) begin
            rdata_OUT = memWrite_IN ? 16'h0000 : mem_rdata;
          end else begin
            stall = 1'b1;
          end
        end else if (halt_IN && !w_req) begin
          halt_OUT = 1'b1;
        end
      end
      BUSY: begin
        if (!w_timeout) begin
          mem_en    = 1'b1;
          mem_wr    = r_holdWr;
          mem_addr  = r_holdAddr;
          mem_wdata = r_holdWdata;
          if (mem_done) begin
            rdata_OUT = r_holdWr ? 16'h0000 : mem_rdata;
          end else begin
            stall = 1'b1;
          end
        end
      end
      HALTED: halt_OUT = 1'b1;
      default: ;
    endcase

    // Drop everything the moment reset asserts, independent of the clock
    if (!rst) begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      stall     = 1'b0;
      rdata_OUT = 16'h0000;
      halt_OUT  = 1'b0;
      err_OUT   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_holdWr    <= 1'b0;
      r_holdAddr  <= 16'h0000;
      r_holdWdata <= 16'h0000;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_misalign) begin
            r_state <= ERR;
          end else if (w_req && !mem_done) begin
            r_state     <= BUSY;
            r_holdWr    <= memWrite_IN;
            r_holdAddr  <= addr_IN;
            r_holdWdata <= wdata_IN;
            r_cnt       <= CNT_W'(1);
          end else if (halt_IN && !w_req) begin
            r_state <= HALTED;
          end
        end
        BUSY: begin
          if (mem_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state <= ERR;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HALTED: r_state <= HALTED;
        default: r_state <= ERR;
      endcase
    end
  end

endmodule
`default_nettype wire
